// File: rtl/lease_sample_drain_if.sv
// Buffer read port and host-bound beat stream of the lease sample drain.
// The master side is the drain engine; the slave side is the RUI buffer plus host comm path.
interface lease_sample_drain_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [31:0]       rd_interval;
  logic [31:0]       rd_address;
  logic [63:0]       rd_trace;
  logic [31:0]       rd_target;

  logic              m_valid;
  logic              m_ready;
  logic [159:0]      m_data;
  logic              m_last;

  modport master (
    output rd_addr, rd_en,
    input  rd_interval, rd_address, rd_trace, rd_target,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  rd_addr, rd_en,
    output rd_interval, rd_address, rd_trace, rd_target,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

// File: rtl/lease_sample_drain.sv
// Drains the lease sampler RUI buffer into 160-bit beats, then pulses the buffer clear.
// Reads are credit-limited so the fixed-latency BRAM return can never overflow the skid FIFO.
module lease_sample_drain #(
  parameter int ADDR_W     = 13,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock_i,
  input  logic                 resetn_i,
  input  logic                 start_i,
  input  logic [31:0]          used_i,
  lease_sample_drain_if.master bus,
  output logic                 busy_o,
  output logic                 clear_o,
  output logic                 done_o,
  output logic [31:0]          beat_count_o,
  output logic [31:0]          neg_count_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  typedef struct packed {
    logic         last;
    logic [159:0] data;
  } entry_t;

  logic [1:0]            state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      issue_q, issue_d;
  logic [RD_LATENCY-1:0] lat_q, lat_d;
  logic [RD_LATENCY-1:0] lat_last_q, lat_last_d;
  entry_t                fifo_q [FIFO_DEPTH];
  entry_t                fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;
  logic [31:0]           neg_cnt_q, neg_cnt_d;

  logic        start_ok;
  logic        issue;
  logic        issue_last;
  logic        push;
  logic        pop;
  logic        m_valid;
  logic [31:0] credit_used;
  entry_t      head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Every read in the latency pipe already owns a FIFO slot.
  always_comb begin
    credit_used = 32'(fifo_cnt_q);
    for (int i = 0; i < RD_LATENCY; i++) begin
      credit_used = credit_used + 32'(lat_q[i]);
    end
  end

  always_comb begin
    start_ok   = (state_q == S_IDLE) && start_i;
    issue      = (state_q == S_RUN) && (issue_q < len_q) &&
                 (credit_used < 32'(FIFO_DEPTH));
    issue_last = (issue_q == len_q - LEN_W'(1));
    push       = lat_q[RD_LATENCY-1];
    m_valid    = (fifo_cnt_q != '0);
    pop        = m_valid && bus.m_ready;
    head       = fifo_q[rd_ptr_q];
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    issue_d = issue_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d   = (used_i > CAPACITY) ? LEN_W'(CAPACITY) : LEN_W'(used_i);
          issue_d = '0;
          state_d = (used_i == 32'd0) ? S_CLEAR : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          issue_d = issue_q + LEN_W'(1);
        end
        // Leave as the final beat is taken so clear_o follows it by one cycle.
        if ((issue_q == len_q) && (lat_q == '0) && (fifo_cnt_d == '0)) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lat_d         = lat_q;
    lat_last_d    = lat_last_q;
    lat_d[0]      = issue;
    lat_last_d[0] = issue && issue_last;
    for (int i = 1; i < RD_LATENCY; i++) begin
      lat_d[i]      = lat_q[i-1];
      lat_last_d[i] = lat_last_q[i-1];
    end
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {lat_last_q[RD_LATENCY-1], bus.rd_target, bus.rd_trace,
                          bus.rd_address, bus.rd_interval};
      wr_ptr_d         = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    neg_cnt_d  = neg_cnt_q;
    if (start_ok) begin
      beat_cnt_d = '0;
      neg_cnt_d  = '0;
    end else if (pop) begin
      if (beat_cnt_q != '1) begin
        beat_cnt_d = beat_cnt_q + 32'd1;
      end
      if (head.data[31] && (neg_cnt_q != '1)) begin
        neg_cnt_d = neg_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issue_q    <= '0;
      lat_q      <= '0;
      lat_last_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      beat_cnt_q <= '0;
      neg_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      lat_q      <= lat_d;
      lat_last_q <= lat_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      neg_cnt_q  <= neg_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  assign bus.rd_en   = issue;
  assign bus.rd_addr = issue_q[ADDR_W-1:0];
  assign bus.m_valid = m_valid;
  assign bus.m_data  = m_valid ? head.data : '0;
  assign bus.m_last  = m_valid && head.last;

  assign busy_o       = (state_q != S_IDLE);
  assign clear_o      = (state_q == S_CLEAR);
  assign done_o       = (state_q == S_CLEAR);
  assign beat_count_o = beat_cnt_q;
  assign neg_count_o  = neg_cnt_q;

  no_push_when_full: assert property (@(posedge clock_i) disable iff (!resetn_i)
    !(push && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_lease_sample_drain.sv
// Directed bench for lease_sample_drain: a table of drains plus hand-written
// sequences for restart-while-busy, reset mid-drain and the clamped full-buffer drain.
module tb_lease_sample_drain;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 8192;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] used;
  logic        busy;
  logic        clear;
  logic        done;
  logic [31:0] beat_count;
  logic [31:0] neg_count;

  lease_sample_drain_if #(.ADDR_W(ADDR_W)) bus ();

  lease_sample_drain #(
    .ADDR_W(ADDR_W),
    .RD_LATENCY(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clock_i(clk),
    .resetn_i(resetn),
    .start_i(start),
    .used_i(used),
    .bus(bus.master),
    .busy_o(busy),
    .clear_o(clear),
    .done_o(done),
    .beat_count_o(beat_count),
    .neg_count_o(neg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: two-stage read pipeline, independent of the drain's reset.
  logic [31:0]       mem_int    [DEPTH];
  logic [31:0]       mem_pc     [DEPTH];
  logic [63:0]       mem_trace  [DEPTH];
  logic [31:0]       mem_target [DEPTH];
  logic [ADDR_W-1:0] p1_addr = '0;
  logic [ADDR_W-1:0] p2_addr = '0;

  always @(posedge clk) begin
    p1_addr <= bus.rd_addr;
    p2_addr <= p1_addr;
  end

  assign bus.rd_interval = mem_int[p2_addr];
  assign bus.rd_address  = mem_pc[p2_addr];
  assign bus.rd_trace    = mem_trace[p2_addr];
  assign bus.rd_target   = mem_target[p2_addr];

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    bus.m_ready = (ready_mode == 0) || (cyc % 3 == 0);
  end

  typedef struct {
    logic [159:0] data;
    logic         last;
    int           cyc;
  } beat_t;

  beat_t beats[$];
  int    rd_en_cnt, addr_err, stable_err, clear_cnt, clear_cyc, done_err;
  int    first_valid_cyc, max_out, exp_addr, start_cyc;
  logic  prev_stall;
  logic [160:0] prev_word;

  always @(negedge clk) begin
    if (bus.rd_en) begin
      rd_en_cnt++;
      if (bus.rd_addr != ADDR_W'(exp_addr)) addr_err++;
      exp_addr++;
    end
    if (rd_en_cnt - beats.size() > max_out) max_out = rd_en_cnt - beats.size();
    if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall && ({bus.m_last, bus.m_data} != prev_word)) stable_err++;
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_word  = {bus.m_last, bus.m_data};
    if (bus.m_valid && bus.m_ready) beats.push_back('{bus.m_data, bus.m_last, cyc});
    if (clear) begin
      clear_cnt++;
      clear_cyc = cyc;
    end
    if (clear != done) done_err++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [160:0] actual,
                             input logic [160:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [159:0] expBeat(input int k);
    return {mem_target[k], mem_trace[k], mem_pc[k], mem_int[k]};
  endfunction

  task automatic fillIntervals(input int pattern);
    logic [31:0] p1 [5];
    p1 = '{32'd10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int k = 0; k < DEPTH; k++) begin
      case (pattern)
        0:       mem_int[k] = 32'(k + 1);
        1:       mem_int[k] = (k < 5) ? p1[k] : 32'd0;
        default: mem_int[k] = (k % 2 == 1) ? (32'h8000_0000 | 32'(k)) : 32'(k);
      endcase
    end
  endtask

  task automatic applyStimulus(input logic [31:0] used_val);
    beats.delete();
    rd_en_cnt = 0; addr_err = 0; stable_err = 0; clear_cnt = 0; clear_cyc = -1;
    done_err = 0; first_valid_cyc = -1; max_out = 0; exp_addr = 0; prev_stall = 1'b0;
    @(posedge clk); #1;
    used      = used_val;
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    used  = 32'hDEAD_BEEF;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (clear_cnt == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("done_timeout", clear_cnt == 0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] used;
    int          pattern;
    int          ready_mode;
    int          exp_beats;
    int          exp_neg;
    int          exp_max_out;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int exp_clear;
    int errs;
    int lasts;

    resetn = 1'b0;
    start  = 1'b0;
    used   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mem_pc[k]     = 32'h1000_0000 + 32'(4 * k);
      mem_trace[k]  = {32'(k) ^ 32'hCAFE_0000, ~32'(k)};
      mem_target[k] = 32'hA500_0000 ^ 32'(7 * k);
    end
    fillIntervals(0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", bus.m_valid, 1'b0);
    checkOutput("rst_m_data", bus.m_data, 160'd0);
    checkOutput("rst_m_last", bus.m_last, 1'b0);
    checkOutput("rst_rd_en", bus.rd_en, 1'b0);
    checkOutput("rst_rd_addr", bus.rd_addr, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_clear", clear, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_beat_count", beat_count, 32'd0);
    checkOutput("rst_neg_count", neg_count, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{32'd3, 0, 0, 3, 0, 3};
    vecs[1] = '{32'd8, 0, 1, 8, 0, 4};
    vecs[2] = '{32'd0, 0, 0, 0, 0, 0};
    vecs[3] = '{32'd5, 1, 0, 5, 3, 4};
    vecs[4] = '{32'd6, 2, 1, 6, 3, 4};
    vecs[5] = '{32'd1, 1, 0, 1, 0, 1};

    for (int v = 0; v < 6; v++) begin
      fillIntervals(vecs[v].pattern);
      ready_mode = vecs[v].ready_mode;
      applyStimulus(vecs[v].used);
      waitDone(vecs[v].exp_beats * 4 + 40);
      n = vecs[v].exp_beats;
      $display("[TB] vector %0d: used=%0d beats=%0d", v, vecs[v].used, beats.size());
      checkOutput("beat_count", beat_count, 32'(n));
      checkOutput("neg_count", neg_count, 32'(vecs[v].exp_neg));
      checkOutput("beats_seen", beats.size(), n);
      checkOutput("rd_en_count", rd_en_cnt, n);
      checkOutput("rd_addr_seq", addr_err, 0);
      checkOutput("hold_stable", stable_err, 0);
      checkOutput("clear_pulses", clear_cnt, 1);
      checkOutput("done_with_clear", done_err, 0);
      checkOutput("busy_after", busy, 1'b0);
      checkOutput("max_outstanding", max_out, vecs[v].exp_max_out);
      if (n == 0) begin
        exp_clear = start_cyc;
      end else if (vecs[v].ready_mode == 0) begin
        exp_clear = start_cyc + 3 + n;
        checkOutput("first_valid", first_valid_cyc, start_cyc + 3);
      end else begin
        exp_clear = (beats.size() > 0) ? beats[beats.size()-1].cyc + 1 : -2;
        checkOutput("first_valid", first_valid_cyc, start_cyc + 3);
      end
      checkOutput("clear_timing", clear_cyc, exp_clear);
      for (int k = 0; k < beats.size(); k++) begin
        checkOutput("beat_data", beats[k].data, expBeat(k));
        checkOutput("beat_last", beats[k].last, k == n - 1);
      end
    end

    // Restart request while draining must be ignored.
    fillIntervals(0);
    ready_mode = 1;
    applyStimulus(32'd4);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    used  = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(100);
    checkOutput("restart_beats", beats.size(), 4);
    checkOutput("restart_beat_count", beat_count, 32'd4);
    checkOutput("restart_rd_en", rd_en_cnt, 4);
    checkOutput("restart_clears", clear_cnt, 1);
    for (int k = 0; k < beats.size(); k++) begin
      checkOutput("restart_data", beats[k].data, expBeat(k));
    end

    // Reset after two beats: abort without clear, late read data dropped.
    ready_mode = 0;
    applyStimulus(32'd10);
    n = 0;
    while (beats.size() < 2 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("reset_wait_timeout", beats.size() < 2, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checkOutput("abort_m_valid", bus.m_valid, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_rd_en", bus.rd_en, 1'b0);
    checkOutput("abort_beat_count", beat_count, 32'd0);
    checkOutput("abort_m_data", bus.m_data, 160'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort_beats", beats.size(), 2);
    checkOutput("abort_no_clear", clear_cnt, 0);
    checkOutput("abort_idle_valid", bus.m_valid, 1'b0);

    // Oversized used_i clamps to the full buffer.
    applyStimulus(32'd9000);
    waitDone(20000);
    checkOutput("big_beat_count", beat_count, 32'd8192);
    checkOutput("big_neg_count", neg_count, 32'd0);
    checkOutput("big_beats", beats.size(), 8192);
    checkOutput("big_rd_en", rd_en_cnt, 8192);
    checkOutput("big_rd_addr_seq", addr_err, 0);
    checkOutput("big_clears", clear_cnt, 1);
    errs  = 0;
    lasts = 0;
    for (int k = 0; k < beats.size(); k++) begin
      if (beats[k].data !== expBeat(k)) errs++;
      if (beats[k].last) lasts++;
    end
    checkOutput("big_data_errors", errs, 0);
    checkOutput("big_last_count", lasts, 1);
    if (beats.size() > 0) begin
      checkOutput("big_final_last", beats[beats.size()-1].last, 1'b1);
      checkOutput("big_last_xfer", beats[beats.size()-1].cyc, start_cyc + 2 + 8192);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
